// File: rtl/jtag_data_register.sv
// Generic JTAG test data register with a shadow update register.
// It has configurable width, IR select code and capture source, and checks the shift length.
module jtag_data_register #(
    parameter int unsigned                WIDTH         = 32,
    parameter int unsigned                IR_WIDTH      = 4,
    parameter logic [IR_WIDTH-1:0]        IR_CODE       = IR_WIDTH'(4'b0010),
    parameter bit                         CAPTURE_MODE  = 1'b1,
    parameter logic [WIDTH-1:0]           CAPTURE_CONST = '0,
    parameter logic [WIDTH-1:0]           UPDATE_RESET  = '0,
    parameter bit                         STRICT_LEN    = 1'b1,
    localparam int unsigned               CNT_W         = $clog2(WIDTH + 2)
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TDI,
    input  logic [3:0]          tap_state,
    input  logic [IR_WIDTH-1:0] IR,
    input  logic [WIDTH-1:0]    capture_data,
    output logic                dr_selected,
    output logic                dr_tdo,
    output logic [WIDTH-1:0]    update_data,
    output logic                update_valid,
    output logic                length_err,
    output logic [CNT_W-1:0]    shift_count
);

    typedef enum logic [3:0] {
        TLR        = 4'b1111,
        CAPTURE_DR = 4'b0110,
        SHIFT_DR   = 4'b0010,
        UPDATE_DR  = 4'b0101
    } tap_state_e;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH + 1);

    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_reg_next;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] update_data_next;
    logic [CNT_W-1:0] shift_count_next;
    logic             update_valid_next;
    logic             length_err_next;
    logic             len_ok;

    assign dr_selected = (IR == IR_CODE);
    assign dr_tdo      = shift_reg[0];
    assign len_ok      = (shift_count == CNT_FULL);

    // TDI enters at the MSB and the LSB leaves first.
    if (WIDTH == 1) begin : g_shift_one
        assign shifted = TDI;
    end else begin : g_shift_many
        assign shifted = {TDI, shift_reg[WIDTH-1:1]};
    end

    // Next-state logic for the shift, count and update registers.
    always_comb begin
        shift_reg_next    = shift_reg;
        shift_count_next  = shift_count;
        update_data_next  = update_data;
        update_valid_next = 1'b0;
        length_err_next   = length_err;
        if (tap_state == TLR) begin
            update_data_next = UPDATE_RESET;
            length_err_next  = 1'b0;
            shift_count_next = '0;
        end else if (dr_selected) begin
            case (tap_state)
                CAPTURE_DR: begin
                    shift_reg_next   = CAPTURE_MODE ? capture_data : CAPTURE_CONST;
                    shift_count_next = '0;
                    length_err_next  = 1'b0;
                end
                SHIFT_DR: begin
                    shift_reg_next = shifted;
                    if (shift_count != CNT_MAX) begin
                        shift_count_next = shift_count + CNT_W'(1);
                    end
                end
                UPDATE_DR: begin
                    if (len_ok || !STRICT_LEN) begin
                        update_data_next  = shift_reg;
                        update_valid_next = 1'b1;
                    end
                    length_err_next = !len_ok;
                end
                default: ;
            endcase
        end
    end

    // State registers, with the test reset taking priority.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            shift_reg    <= '0;
            shift_count  <= '0;
            update_data  <= UPDATE_RESET;
            update_valid <= 1'b0;
            length_err   <= 1'b0;
        end else begin
            shift_reg    <= shift_reg_next;
            shift_count  <= shift_count_next;
            update_data  <= update_data_next;
            update_valid <= update_valid_next;
            length_err   <= length_err_next;
        end
    end

endmodule

// File: tb/tb_jtag_data_register.sv
// Bench for jtag_data_register: a strict instance and a lenient instance share one set of stimulus.
// A behavioural model checks both instances after every TCK.
module tb_jtag_data_register;

    localparam logic [3:0] ST_TLR = 4'hF;
    localparam logic [3:0] ST_CAP = 4'h6;
    localparam logic [3:0] ST_SHF = 4'h2;
    localparam logic [3:0] ST_UPD = 4'h5;
    localparam logic [3:0] ST_IDL = 4'h0;
    localparam logic [3:0] CODE   = 4'h2;
    localparam logic [3:0] OTHER  = 4'h7;

    logic       TCK = 1'b0;
    logic       TRST;
    logic       TDI;
    logic [3:0] tap_state;
    logic [3:0] IR;
    logic [7:0] capture_data;

    logic       s_sel, s_tdo, s_valid, s_err;
    logic [7:0] s_upd;
    logic [3:0] s_cnt;
    logic       l_sel, l_tdo, l_valid, l_err;
    logic [7:0] l_upd;
    logic [3:0] l_cnt;

    always #5 TCK = ~TCK;

    jtag_data_register #(.WIDTH(8), .IR_WIDTH(4), .IR_CODE(4'b0010), .CAPTURE_MODE(1'b1),
        .CAPTURE_CONST(8'h00), .UPDATE_RESET(8'hA5), .STRICT_LEN(1'b1)) dut_s (
        .TCK(TCK), .TRST(TRST), .TDI(TDI), .tap_state(tap_state), .IR(IR),
        .capture_data(capture_data), .dr_selected(s_sel), .dr_tdo(s_tdo),
        .update_data(s_upd), .update_valid(s_valid), .length_err(s_err), .shift_count(s_cnt));

    jtag_data_register #(.WIDTH(8), .IR_WIDTH(4), .IR_CODE(4'b0010), .CAPTURE_MODE(1'b0),
        .CAPTURE_CONST(8'h5A), .UPDATE_RESET(8'h00), .STRICT_LEN(1'b0)) dut_l (
        .TCK(TCK), .TRST(TRST), .TDI(TDI), .tap_state(tap_state), .IR(IR),
        .capture_data(capture_data), .dr_selected(l_sel), .dr_tdo(l_tdo),
        .update_data(l_upd), .update_valid(l_valid), .length_err(l_err), .shift_count(l_cnt));

    int checks = 0;
    int errors = 0;

    // Model state per instance: index 0 is the strict instance and index 1 is the lenient instance.
    logic [7:0] m_sr    [2];
    logic [7:0] m_upd   [2];
    int         m_cnt   [2];
    logic       m_valid [2];
    logic       m_err   [2];

    function automatic logic [7:0] reset_val(input int i);
        return (i == 0) ? 8'hA5 : 8'h00;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit ok;
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 1'b0;
            if (TRST) begin
                m_sr[i]  = 8'h00;
                m_cnt[i] = 0;
                m_upd[i] = reset_val(i);
                m_err[i] = 1'b0;
            end else if (tap_state == ST_TLR) begin
                m_upd[i] = reset_val(i);
                m_err[i] = 1'b0;
                m_cnt[i] = 0;
            end else if (IR == CODE) begin
                if (tap_state == ST_CAP) begin
                    m_sr[i]  = (i == 0) ? capture_data : 8'h5A;
                    m_cnt[i] = 0;
                    m_err[i] = 1'b0;
                end else if (tap_state == ST_SHF) begin
                    m_sr[i]  = (m_sr[i] >> 1) | (TDI ? 8'h80 : 8'h00);
                    m_cnt[i] = (m_cnt[i] < 9) ? m_cnt[i] + 1 : 9;
                end else if (tap_state == ST_UPD) begin
                    ok = (m_cnt[i] == 8);
                    if (ok || i == 1) begin
                        m_upd[i]   = m_sr[i];
                        m_valid[i] = 1'b1;
                    end
                    m_err[i] = !ok;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("s_sel",   32'(s_sel),   32'(IR == CODE));
        chk("s_tdo",   32'(s_tdo),   32'(m_sr[0][0]));
        chk("s_upd",   32'(s_upd),   32'(m_upd[0]));
        chk("s_valid", 32'(s_valid), 32'(m_valid[0]));
        chk("s_err",   32'(s_err),   32'(m_err[0]));
        chk("s_cnt",   32'(s_cnt),   32'(m_cnt[0]));
        chk("l_sel",   32'(l_sel),   32'(IR == CODE));
        chk("l_tdo",   32'(l_tdo),   32'(m_sr[1][0]));
        chk("l_upd",   32'(l_upd),   32'(m_upd[1]));
        chk("l_valid", 32'(l_valid), 32'(m_valid[1]));
        chk("l_err",   32'(l_err),   32'(m_err[1]));
        chk("l_cnt",   32'(l_cnt),   32'(m_cnt[1]));
    endtask

    task automatic step(input logic [3:0] st, input logic [3:0] ir, input logic tdi, input logic rst);
        tap_state = st;
        IR        = ir;
        TDI       = tdi;
        TRST      = rst;
        @(posedge TCK);
        model_step();
        #1;
        check_all();
    endtask

    initial begin
        logic [7:0]  tdo_exp;
        logic [7:0]  tdi_val;
        logic [10:0] long_val;
        logic [3:0]  ir_r;
        int          n;

        for (int i = 0; i < 2; i++) begin
            m_sr[i] = 8'h00; m_upd[i] = 8'h00; m_cnt[i] = 0; m_valid[i] = 1'b0; m_err[i] = 1'b0;
        end
        capture_data = 8'h3C;
        tap_state = ST_IDL; IR = CODE; TDI = 1'b0; TRST = 1'b1;

        // Reset for two cycles
        step(ST_IDL, CODE, 1'b0, 1'b1);
        step(ST_IDL, CODE, 1'b0, 1'b1);
        chk("rst_upd", 32'(s_upd), 32'h0000_00A5);
        chk("rst_tdo", 32'(s_tdo), 32'h0);
        chk("rst_cnt", 32'(s_cnt), 32'h0);

        // Capture 3C, shift in 96, then update
        tdo_exp = 8'h3C;
        tdi_val = 8'h96;
        step(ST_CAP, CODE, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            chk("tdo_seq", 32'(s_tdo), 32'(tdo_exp[i]));
            step(ST_SHF, CODE, tdi_val[i], 1'b0);
        end
        step(ST_UPD, CODE, 1'b0, 1'b0);
        chk("upd_96", 32'(s_upd), 32'h0000_0096);
        chk("upd_96_valid", 32'(s_valid), 32'h1);
        chk("upd_96_err", 32'(s_err), 32'h0);
        step(ST_IDL, CODE, 1'b0, 1'b0);
        chk("valid_one_cycle", 32'(s_valid), 32'h0);

        // Short shift: the strict instance rejects it and the lenient one commits it
        step(ST_CAP, CODE, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(ST_SHF, CODE, 1'(i & 1), 1'b0);
        step(ST_UPD, CODE, 1'b0, 1'b0);
        chk("short_upd_held", 32'(s_upd), 32'h0000_0096);
        chk("short_err", 32'(s_err), 32'h1);
        chk("short_no_valid", 32'(s_valid), 32'h0);
        step(ST_CAP, CODE, 1'b0, 1'b0);
        chk("cap_clears_err", 32'(s_err), 32'h0);

        // Long shift: the counter saturates and the last 8 bits are committed
        long_val = 11'h596;
        for (int i = 0; i < 11; i++) step(ST_SHF, CODE, long_val[i], 1'b0);
        chk("long_cnt_sat", 32'(l_cnt), 32'h9);
        step(ST_UPD, CODE, 1'b0, 1'b0);
        chk("long_upd", 32'(l_upd), 32'h0000_00B2);
        chk("long_valid", 32'(l_valid), 32'h1);
        chk("long_err", 32'(l_err), 32'h1);

        // Deselected: a full capture/shift/update has no effect
        step(ST_CAP, OTHER, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(ST_SHF, OTHER, 1'b1, 1'b0);
        step(ST_UPD, OTHER, 1'b0, 1'b0);
        chk("desel_sel", 32'(s_sel), 32'h0);
        chk("desel_valid", 32'(s_valid), 32'h0);

        // Commit 96 again, then enter Test-Logic-Reset
        step(ST_CAP, CODE, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(ST_SHF, CODE, tdi_val[i], 1'b0);
        step(ST_UPD, CODE, 1'b0, 1'b0);
        step(ST_TLR, OTHER, 1'b0, 1'b0);
        chk("tlr_upd", 32'(s_upd), 32'h0000_00A5);

        // TRST in the middle of Shift-DR
        step(ST_CAP, CODE, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(ST_SHF, CODE, 1'b1, 1'b0);
        step(ST_SHF, CODE, 1'b1, 1'b1);
        chk("trst_cnt", 32'(s_cnt), 32'h0);
        chk("trst_tdo", 32'(s_tdo), 32'h0);

        // Random transactions, with occasional IR flips, TLR and TRST
        for (int t = 0; t < 60; t++) begin
            capture_data = 8'($urandom);
            step(ST_CAP, ($urandom_range(0, 7) == 0) ? OTHER : CODE, 1'b0, 1'b0);
            n = $urandom_range(5, 11);
            for (int i = 0; i < n; i++) begin
                ir_r = ($urandom_range(0, 9) == 0) ? OTHER : CODE;
                step(ST_SHF, ir_r, 1'($urandom), ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0);
            end
            step(ST_UPD, CODE, 1'b0, 1'b0);
            if ($urandom_range(0, 3) == 0) step(ST_UPD, CODE, 1'b0, 1'b0);
            step(($urandom_range(0, 7) == 0) ? ST_TLR : ST_IDL, 4'($urandom), 1'b0, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jtag_data_register.md
Name: jtag_data_register

Overview:
Generic JTAG test data register for the TAP datapath. It is the parametrised successor to the single-bit bypass cell, with configurable width, IR select code and capture source. It adds a shadow update register with a one-cycle valid pulse and shift-length checking. It sits beside the bypass/IDCODE registers behind the TDO mux and is driven by the TAP controller's tap_state and IR outputs.

Parameters:
WIDTH, 32, shift/update register length in bits (>=1)
IR_WIDTH, 4, width of IR input
IR_CODE, 4'b0010, IR value that selects this register
CAPTURE_MODE, 1, 1 = load capture_data at Capture-DR; 0 = load CAPTURE_CONST
CAPTURE_CONST, {WIDTH{1'b0}}, constant loaded when CAPTURE_MODE=0
UPDATE_RESET, {WIDTH{1'b0}}, value of update_data after reset / Test-Logic-Reset
STRICT_LEN, 1, 1 = Update-DR commits only when exactly WIDTH bits were shifted

Ports:
TCK  input  1  test clock; all state updates on rising edge
TRST  input  1  reset, synchronous, active-high
TDI  input  1  serial data in
tap_state  input  4  TAP state: TLR=1111, CAPTURE_DR=0110, SHIFT_DR=0010, UPDATE_DR=0101
IR  input  IR_WIDTH  current instruction
capture_data  input  WIDTH  parallel value sampled at Capture-DR
dr_selected  output  1  IR==IR_CODE (combinational)
dr_tdo  output  1  shift_reg[0] (combinational)
update_data  output  WIDTH  committed parallel output
update_valid  output  1  one-TCK pulse when update_data is written
length_err  output  1  last Update-DR saw shift count != WIDTH
shift_count  output  clog2(WIDTH+2)  bits shifted since last Capture-DR, saturating

Behaviour:
- Reset: one clock is synchronous only; reset is synchronous, active-high, sampled on rising TCK. TRST=1 sets shift_reg=0, shift_count=0, update_data=UPDATE_RESET, update_valid=0, length_err=0. TRST has priority over all other actions.
- sel = (IR==IR_CODE). Capture/Shift/Update act only when sel=1. Otherwise shift_reg and shift_count hold.
- Capture-DR & sel:
  - shift_reg <= CAPTURE_MODE ? capture_data : CAPTURE_CONST
  - shift_count <= 0
  - length_err <= 0
- Shift-DR & sel:
  - shift_reg <= {TDI, shift_reg[WIDTH-1:1]}. LSB exits first; TDI enters at MSB. WIDTH=1 gives shift_reg <= TDI.
  - shift_count increments and saturates at WIDTH+1 (never wraps).
- Update-DR & sel:
  - ok = (shift_count==WIDTH).
  - If ok or STRICT_LEN=0: update_data <= shift_reg and update_valid=1 for exactly the next cycle.
  - length_err <= !ok, independent of STRICT_LEN.
  - shift_reg is unchanged.
- update_valid is 0 in every cycle except the single cycle after a committing Update-DR. Consecutive Update-DR cycles (not legal TAP behaviour) produce one pulse per cycle.
- Test-Logic-Reset (1111), regardless of IR: update_data <= UPDATE_RESET, length_err <= 0, shift_count <= 0, update_valid=0. shift_reg holds.
- IR change mid-shift: shifting stops, and contents and count are retained. Re-selection without a new Capture-DR continues from the retained state.
- dr_tdo is driven whether or not the register is selected; external TDO mux gates it.
- Latency: capture value appears on dr_tdo the cycle after Capture-DR. update_data changes the cycle after Update-DR.
- All other tap_state values: hold all registers; update_valid=0.

Test Plan:
- Reset: TRST=1 for 2 cycles with WIDTH=8, UPDATE_RESET=8'hA5 -> update_data=8'hA5, update_valid=0, length_err=0, shift_count=0, dr_tdo=0.
- Capture/shift/update, WIDTH=8, IR=IR_CODE:
  - Stimulus: capture_data=8'h3C; Capture-DR; 8 Shift-DR cycles with TDI = bits of 8'h96 LSB first; then Update-DR.
  - Response: dr_tdo emits 0,0,1,1,1,1,0,0; update_data=8'h96; update_valid high exactly 1 cycle; length_err=0.
- Short shift, STRICT_LEN=1: only 5 shifts before Update-DR -> update_data unchanged, update_valid=0, length_err=1. The next Capture-DR clears length_err.
- Long shift, STRICT_LEN=0: 11 shifts -> shift_count saturates at 9, update_data = last 8 TDI bits, update_valid pulses, length_err=1.
- Deselected: IR != IR_CODE through a full Capture/Shift/Update -> shift_reg, update_data and shift_count unchanged; update_valid=0; dr_selected=0.
- TLR and mid-op reset:
  - Enter TLR after a committed update of 8'h96 -> update_data=UPDATE_RESET.
  - Assert TRST during Shift-DR -> next cycle all reset values, shifting resumes only after a new Capture-DR.
